// File: rtl/wb_check_pkg.sv
// rtl/wb_check_pkg.sv - shared types and constants for the writeback result checker
package wb_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    // Writes to $zero never retire a check; the CPU discards them.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/wb_expect_table.sv
// rtl/wb_expect_table.sv - expectation table: (addr, data) pairs, sync write, async read
module wb_expect_table
    import wb_check_pkg::*;
#(
    parameter int NUM_CHECKS = 4,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int IDX_W      = 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W:0]    rd_idx,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [ADDR_W-1:0] addr_q [NUM_CHECKS];
    logic [DATA_W-1:0] data_q [NUM_CHECKS];
    logic [ADDR_W-1:0] addr_d [NUM_CHECKS];
    logic [DATA_W-1:0] data_d [NUM_CHECKS];

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (we && (32'(wr_idx) < NUM_CHECKS)) begin
            addr_d[wr_idx] = wr_addr;
            data_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // Index one past the last entry reads as zero rather than aliasing.
    always_comb begin
        rd_addr = '0;
        rd_data = '0;
        if (32'(rd_idx) < NUM_CHECKS) begin
            rd_addr = addr_q[rd_idx[IDX_W-1:0]];
            rd_data = data_q[rd_idx[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/wb_result_checker.sv
// rtl/wb_result_checker.sv - writeback scoreboard: ordered register-write matching with pass/fail/timeout
module wb_result_checker
    import wb_check_pkg::*;
#(
    parameter int NUM_CHECKS = 4,
    parameter int TIMEOUT    = 2500,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regwrite_en,
    input  logic [ADDR_W-1:0] regwrite_addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [IDX_W:0]    num_checks,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic              hit,
    output logic [IDX_W:0]    check_idx,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [DATA_W-1:0] fail_data
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W:0]    active_n_q, active_n_d;
    logic [IDX_W:0]    check_idx_q, check_idx_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic              fail_q, fail_d, timeout_q, timeout_d, hit_q, hit_d;

    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [IDX_W:0]    n_clamp, check_inc;
    logic              consume, last, expired;

    wb_expect_table #(
        .NUM_CHECKS (NUM_CHECKS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk     (clk),
        .clr_n   (reset),
        .we      (cfg_we && (state_q != ST_ARMED)),
        .wr_idx  (cfg_idx),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_idx  (check_idx_q),
        .rd_addr (exp_addr),
        .rd_data (exp_data)
    );

    always_comb begin
        n_clamp   = (32'(num_checks) > NUM_CHECKS) ? (IDX_W+1)'(NUM_CHECKS) : num_checks;
        check_inc = check_idx_q + 1'b1;
        consume   = (state_q == ST_ARMED) && regwrite_en && (regwrite_addr == exp_addr)
                    && (regwrite_addr != ADDR_W'(ZERO_REG));
        last      = consume && (check_inc == active_n_q);
        expired   = (state_q == ST_ARMED) && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        active_n_d  = active_n_q;
        check_idx_d = check_idx_q;
        fail_idx_d  = fail_idx_q;
        fail_data_d = fail_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        hit_d       = 1'b0;

        if (start) begin
            check_idx_d = '0;
            cnt_d       = '0;
            fail_d      = 1'b0;
            timeout_d   = 1'b0;
            fail_idx_d  = '0;
            fail_data_d = '0;
            active_n_d  = n_clamp;
            if (n_clamp == '0) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = 1'b1;
            end else begin
                state_d = ST_ARMED;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        end else if (state_q == ST_ARMED) begin
            cnt_d = cnt_q + 1'b1;
            if (consume) begin
                hit_d       = 1'b1;
                check_idx_d = check_inc;
                if ((reg_data != exp_data) && !fail_q) begin
                    fail_d      = 1'b1;
                    fail_idx_d  = check_idx_q[IDX_W-1:0];
                    fail_data_d = reg_data;
                end
            end
            // A final consume on the expiry cycle counts as completion, not timeout.
            if (last || expired) begin
                state_d   = ST_DONE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                timeout_d = !last;
                pass_d    = !fail_d && !timeout_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            active_n_q  <= '0;
            check_idx_q <= '0;
            fail_idx_q  <= '0;
            fail_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            active_n_q  <= active_n_d;
            check_idx_q <= check_idx_d;
            fail_idx_q  <= fail_idx_d;
            fail_data_q <= fail_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            hit_q       <= hit_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign hit       = hit_q;
    assign check_idx = check_idx_q;
    assign fail_idx  = fail_idx_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_wb_result_checker.sv
// tb/tb_wb_result_checker.sv - directed self-checking bench for wb_result_checker
module tb_wb_result_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        regwrite_en;
    logic [4:0]  regwrite_addr;
    logic [31:0] reg_data;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [2:0]  num_checks;
    logic        start;
    logic        busy, done, pass, fail, timeout, hit;
    logic [2:0]  check_idx;
    logic [1:0]  fail_idx;
    logic [31:0] fail_data;

    int n_checks = 0;
    int n_fail   = 0;
    int hits;

    always #5 clk = ~clk;

    wb_result_checker #(
        .NUM_CHECKS (4),
        .TIMEOUT    (300),
        .ADDR_W     (5),
        .DATA_W     (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .regwrite_en   (regwrite_en),
        .regwrite_addr (regwrite_addr),
        .reg_data      (reg_data),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .num_checks    (num_checks),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .timeout       (timeout),
        .hit           (hit),
        .check_idx     (check_idx),
        .fail_idx      (fail_idx),
        .fail_data     (fail_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int idx, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_idx  = 2'(idx);
        cfg_addr = 5'(addr);
        cfg_data = 32'(data);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        num_checks = 3'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic reg_wr(input int addr, input int data);
        regwrite_en   = 1'b1;
        regwrite_addr = 5'(addr);
        reg_data      = 32'(data);
        tick();
        regwrite_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; regwrite_en = 1'b0; regwrite_addr = '0; reg_data = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        num_checks = '0; start = 1'b0;
        wait_ticks(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_check_idx", check_idx, 0);
        reset = 1'b1;
        tick();

        // single check {2:25}
        cfg_write(0, 2, 25);
        do_start(1);
        chk("t1_busy", busy, 1);
        chk("t1_idx0", check_idx, 0);
        reg_wr(2, 25);
        chk("t1_hit", hit, 1);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_busy_low", busy, 0);
        chk("t1_idx1", check_idx, 1);
        tick();
        chk("t1_hit_pulse", hit, 0);
        chk("t1_done_hold", done, 1);

        // four checks, num_checks=7 clamps to 4
        cfg_write(0, 16, 1);
        cfg_write(1, 17, 12);
        cfg_write(2, 18, 9);
        cfg_write(3, 19, 64);
        do_start(7);
        hits = 0;
        reg_wr(8, 3);   if (hit) hits++;
        reg_wr(17, 12); if (hit) hits++;
        chk("t2_out_of_order", check_idx, 0);
        reg_wr(16, 1);  if (hit) hits++;
        reg_wr(9, 5);   if (hit) hits++;
        reg_wr(17, 12); if (hit) hits++;
        reg_wr(8, 0);   if (hit) hits++;
        reg_wr(18, 9);  if (hit) hits++;
        chk("t2_not_done", done, 0);
        reg_wr(19, 64); if (hit) hits++;
        chk("t2_hits", hits, 4);
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 1);
        chk("t2_idx", check_idx, 4);

        // mismatch {2:12}, observe 13
        cfg_write(0, 2, 12);
        do_start(1);
        reg_wr(2, 13);
        chk("t3_fail", fail, 1);
        chk("t3_fail_idx", fail_idx, 0);
        chk("t3_fail_data", fail_data, 13);
        chk("t3_done", done, 1);
        chk("t3_pass", pass, 0);

        // timeout: done exactly 300 cycles after busy rises
        do_start(1);
        chk("t4_busy", busy, 1);
        chk("t4_fail_cleared", fail, 0);
        wait_ticks(299);
        chk("t4_done_early", done, 0);
        chk("t4_timeout_early", timeout, 0);
        tick();
        chk("t4_done", done, 1);
        chk("t4_timeout", timeout, 1);
        chk("t4_pass", pass, 0);
        chk("t4_busy_low", busy, 0);

        // collision: final match sampled on counter == TIMEOUT-1
        do_start(1);
        wait_ticks(299);
        chk("t5_pre_done", done, 0);
        reg_wr(2, 12);
        chk("t5_hit", hit, 1);
        chk("t5_done", done, 1);
        chk("t5_timeout", timeout, 0);
        chk("t5_pass", pass, 1);

        // restart while ARMED re-zeros index and counter
        cfg_write(0, 5, 7);
        cfg_write(1, 6, 8);
        do_start(2);
        reg_wr(5, 7);
        chk("t6_idx1", check_idx, 1);
        wait_ticks(10);
        do_start(2);
        chk("t6_idx0", check_idx, 0);
        chk("t6_busy", busy, 1);
        wait_ticks(299);
        chk("t6_counter_restart", done, 0);
        tick();
        chk("t6_done", done, 1);
        chk("t6_timeout", timeout, 1);

        // asynchronous reset mid-run
        do_start(2);
        reg_wr(5, 7);
        chk("t7_hit", hit, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_hit0", hit, 0);
        chk("t7_idx", check_idx, 0);
        chk("t7_done", done, 0);
        chk("t7_fail_data", fail_data, 0);
        chk("t7_tbl_addr0", dut.u_table.addr_q[0], 0);
        chk("t7_tbl_data0", dut.u_table.data_q[0], 0);
        chk("t7_tbl_addr1", dut.u_table.addr_q[1], 0);
        reset = 1'b1;
        tick();
        chk("t7_idle_busy", busy, 0);

        // cleared table, $zero writes and cfg writes while ARMED never match
        do_start(1);
        reg_wr(5, 7);
        chk("t8_old_entry", hit, 0);
        reg_wr(0, 0);
        chk("t8_zero_reg", hit, 0);
        cfg_write(0, 3, 4);
        reg_wr(3, 4);
        chk("t8_cfg_armed", hit, 0);
        chk("t8_busy", busy, 1);

        // num_checks = 0 passes immediately
        do_start(0);
        chk("t9_done", done, 1);
        chk("t9_pass", pass, 1);
        chk("t9_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_result_checker.md
# wb_result_checker

Synthesizable writeback scoreboard that sits directly downstream of the CPU's register-file write port. It watches every register write, matches an ordered list of expected (register, value) pairs, and reports pass, fail or timeout. It replaces hand-written per-program tester blocks with one reusable, self-timed checker that runs in simulation or on an FPGA. Covered programs include multiply, LCM and recursive exponent.

## Interface
Parameters:
- `NUM_CHECKS`, default 4: depth of the expectation table, ≥1.
- `TIMEOUT`, default 2500: cycles allowed in ARMED before timeout, ≥1.
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register data width.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `regwrite_en`  in  1  CPU register-file write strobe.
- `regwrite_addr`  in  ADDR_W  CPU write address.
- `reg_data`  in  DATA_W  CPU write data.
- `cfg_we`  in  1  expectation-table write strobe.
- `cfg_idx`  in  IDX_W  table entry to write. IDX_W = max(1, clog2(NUM_CHECKS)).
- `cfg_addr`  in  ADDR_W  expected register address.
- `cfg_data`  in  DATA_W  expected value.
- `num_checks`  in  IDX_W+1  number of active entries; sampled on `start`.
- `start`  in  1  one-cycle pulse that arms the checker.
- `busy`  out  1  high in ARMED.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid with `done`. High only if every check matched and there was no timeout.
- `fail`  out  1  sticky flag; set on the first mismatch.
- `timeout`  out  1  sticky flag; set when the cycle budget expires.
- `hit`  out  1  one-cycle pulse when a check is consumed, whether it matched or mismatched.
- `check_idx`  out  IDX_W+1  index of the next check to consume.
- `fail_idx`  out  IDX_W  index of the first mismatching check.
- `fail_data`  out  DATA_W  value observed at the first mismatch.

## Operation
- States: IDLE, ARMED, DONE.
- IDLE:
  - `start` with `num_checks`=0 goes to DONE with `pass`=1.
  - `start` with any other `num_checks` goes to ARMED.
  - On entering ARMED, clear `check_idx`, the cycle counter, `fail`, `timeout`, `fail_idx` and `fail_data`.
- ARMED, a check is consumed on a cycle where all of these hold:
  - `regwrite_en`=1;
  - `regwrite_addr` equals the expected address at `check_idx`;
  - `regwrite_addr`≠0.
- On a consumed check:
  - Pulse `hit` and increment `check_idx`.
  - If the data differs and `fail`=0, set `fail` and capture `fail_idx` and `fail_data`.
  - A mismatch does not abort the run; later checks are still evaluated.
- Writes to any other address are ignored. Checks are consumed strictly in order, so a matching write for a later entry is ignored.
- ARMED to DONE transitions:
  - On the cycle the last active check is consumed.
  - When the cycle counter reaches TIMEOUT-1 without the final check being consumed. This sets `timeout`.
  - If the final consume and the timeout happen on the same cycle, the consume wins and `timeout` stays 0.
- `pass` = !`fail` && !`timeout`. It is registered on entry to DONE.
- DONE holds all outputs until the next `start`, which re-arms exactly as from IDLE.
- `start` while ARMED restarts the run: clears status and index, and re-samples `num_checks`.
- `cfg_we` is honoured only in IDLE and DONE; it is ignored while ARMED.
- `num_checks` > NUM_CHECKS is clamped to NUM_CHECKS.

## Timing
- Reset (`reset`=0) takes effect immediately, asynchronously:
  - state goes to IDLE;
  - every output goes to 0;
  - every expectation-table entry goes to 0.
- Reset mid-run aborts the run with no `done` pulse.
- Latency:
  - `busy` rises one cycle after `start`.
  - `hit` and `check_idx` update one cycle after the consuming write is sampled.
  - `done` rises on the same edge as the final `hit`.
- The timeout counter runs only in ARMED and counts from 0 on the first ARMED cycle. `done` is high after exactly TIMEOUT ARMED cycles.
- A table write completes in one cycle. An entry written on cycle N is readable on cycle N+1, so a `start` issued on cycle N+1 uses the new value.

## Structure
- Package `wb_check_pkg` holds:
  - the state enum (IDLE/ARMED/DONE);
  - defaults for ADDR_W and DATA_W;
  - the `$zero` register address constant.
- Sub-module `wb_expect_table`: an NUM_CHECKS-entry register file for (addr, data) pairs. It has one synchronous write port, one asynchronous read port and an async active-low clear.
- The top level contains the FSM, the cycle counter and the status registers.

## Test plan
- Single check, table = {2:25}. Start, then write reg 2 = 25 → one `hit`; `done`=1 and `pass`=1 on that edge.
- Four checks, table = {16:1, 17:12, 18:9, 19:64}:
  - Interleave writes to regs 8/9.
  - Write reg 17 before reg 16 has matched.
  - Expect exactly 4 `hit` pulses and a final `pass`=1.
- Mismatch, table = {2:12}. Write reg 2 = 13 → `fail`=1, `fail_idx`=0, `fail_data`=13, `done`=1, `pass`=0.
- Timeout with TIMEOUT=300 and no matching writes → `done` and `timeout` rise exactly 300 cycles after `busy` rises; `pass`=0.
- Collision: the final match lands on the cycle the counter reaches TIMEOUT-1 → `timeout`=0, `pass`=1.
- Reset and restart:
  - Drop `reset` mid-ARMED → all outputs 0 immediately and the table reads 0.
  - Reload the table, then `start` while ARMED → `check_idx` returns to 0 and the counter restarts.
